// File: rtl/mem_pkg.sv
// Shared status codes and copy-engine FSM encoding for the memory copy engine.
package mem_pkg;

  localparam logic [3:0] MEM_OK         = 4'h0;
  localparam logic [3:0] MEM_ERR_ADDR   = 4'h1;
  localparam logic [3:0] MEM_ERR_ACCESS = 4'h2;

  typedef enum logic [1:0] {
    COPY_IDLE,
    COPY_RUN,
    COPY_DRAIN,
    COPY_DONE
  } copy_state_e;

endpackage

// File: rtl/mem_copy_fifo.sv
// Synchronous read-data buffer for the copy engine; head word is visible
// combinationally, occupancy is exported so the engine can reserve space.
module mem_copy_fifo
  import mem_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (count == '0);
  assign do_push   = push && (count != CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // NOTE: storage is not reset; only pointers and count need a defined value.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Copy engine: pipelined reads into a space-reserved buffer, matching writes, sticky status.
// Optional MEM_COPY_PERF_EN adds perf_cycles (saturating RUN+DRAIN cycle count).
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned VIRT_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [VIRT_ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [VIRT_ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       done_valid,
  input  logic                       done_ready,
  output logic [3:0]                 done_status,
  output logic [LEN_WIDTH-1:0]       done_count,
  output logic                       read_req_valid,
  input  logic                       read_req_ready,
  output logic [VIRT_ADDR_WIDTH-1:0] read_req_addr,
  output logic [DATA_WIDTH/8-1:0]    read_req_mask,
  input  logic                       read_resp_valid,
  output logic                       read_resp_ready,
  input  logic [DATA_WIDTH-1:0]      read_resp_data,
  input  logic [3:0]                 read_resp_status,
  output logic                       write_req_valid,
  input  logic                       write_req_ready,
  output logic [VIRT_ADDR_WIDTH-1:0] write_req_addr,
  output logic [DATA_WIDTH/8-1:0]    write_req_mask,
  output logic [DATA_WIDTH-1:0]      write_req_data,
  input  logic                       write_resp_valid,
  output logic                       write_resp_ready,
  input  logic [3:0]                 write_resp_status
`ifdef MEM_COPY_PERF_EN
  ,
  output logic [31:0]                perf_cycles
`endif
);

  localparam int unsigned MASK_W     = DATA_WIDTH / 8;
  localparam int unsigned ADDR_SHIFT = $clog2(MASK_W);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  copy_state_e state, state_nxt;

  logic [VIRT_ADDR_WIDTH-1:0] src_base, dst_base;
  logic [LEN_WIDTH-1:0]       len_q, rd_issued, wr_issued, wr_out, done_count_q;
  logic [CNT_W-1:0]           rd_inflight;
  logic                       rd_hold, wr_hold, err;
  logic [3:0]                 status_q;

  logic cmd_fire, rd_fire, rresp_fire, wr_fire, wresp_fire, rresp_err, wresp_err;
  logic busy, all_read_issued, quiet, fifo_push, fifo_empty;
  logic [CNT_W:0]             buf_used;
  logic [CNT_W-1:0]           fifo_count;
  logic [DATA_WIDTH-1:0]      fifo_head;

  assign busy            = (state == COPY_RUN) || (state == COPY_DRAIN);
  assign cmd_fire        = cmd_valid && cmd_ready;
  assign rd_fire         = read_req_valid && read_req_ready;
  assign rresp_fire      = read_resp_valid && read_resp_ready;
  assign wr_fire         = write_req_valid && write_req_ready;
  assign wresp_fire      = write_resp_valid && write_resp_ready;
  assign rresp_err       = rresp_fire && (read_resp_status != MEM_OK);
  assign wresp_err       = wresp_fire && (write_resp_status != MEM_OK);
  assign fifo_push       = rresp_fire && (read_resp_status == MEM_OK);
  assign all_read_issued = (rd_issued == len_q);
  // Reads in flight plus buffered words: a read may issue only if its data has a guaranteed slot.
  assign buf_used        = (CNT_W+1)'(rd_inflight) + (CNT_W+1)'(fifo_count);
  assign quiet           = (rd_inflight == '0) && (wr_out == '0) && !rd_hold && !wr_hold;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; comb blocks use =.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COPY_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      COPY_IDLE:  if (cmd_valid) state_nxt = (cmd_len == '0) ? COPY_DONE : COPY_RUN;
      COPY_RUN:   if (all_read_issued || err) state_nxt = COPY_DRAIN;
      COPY_DRAIN: if (quiet && (err || fifo_empty)) state_nxt = COPY_DONE;
      COPY_DONE:  if (done_ready) state_nxt = COPY_IDLE;
      default:    state_nxt = COPY_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready        = (state == COPY_IDLE);
    done_valid       = (state == COPY_DONE);
    read_resp_ready  = busy;
    write_resp_ready = busy;
    // A hold keeps an un-accepted request asserted even after an error stops new issue.
    read_req_valid   = rd_hold ||
                       ((state == COPY_RUN) && !all_read_issued && !err &&
                        (buf_used < (CNT_W+1)'(FIFO_DEPTH)));
    write_req_valid  = wr_hold || (busy && !fifo_empty && !err);
  end

  assign read_req_addr  = src_base + (VIRT_ADDR_WIDTH'(rd_issued) << ADDR_SHIFT);
  assign write_req_addr = dst_base + (VIRT_ADDR_WIDTH'(wr_issued) << ADDR_SHIFT);
  assign read_req_mask  = {MASK_W{read_req_valid}};
  assign write_req_mask = {MASK_W{write_req_valid}};
  assign write_req_data = write_req_valid ? fifo_head : '0;
  assign done_status    = status_q;
  assign done_count     = done_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base     <= '0;
      dst_base     <= '0;
      len_q        <= '0;
      rd_issued    <= '0;
      wr_issued    <= '0;
      wr_out       <= '0;
      rd_inflight  <= '0;
      rd_hold      <= 1'b0;
      wr_hold      <= 1'b0;
      err          <= 1'b0;
      status_q     <= MEM_OK;
      done_count_q <= '0;
    end else begin
      rd_hold <= read_req_valid && !read_req_ready;
      wr_hold <= write_req_valid && !write_req_ready;
      if (cmd_fire) begin
        src_base     <= cmd_src_addr;
        dst_base     <= cmd_dst_addr;
        len_q        <= cmd_len;
        rd_issued    <= '0;
        wr_issued    <= '0;
        wr_out       <= '0;
        rd_inflight  <= '0;
        err          <= 1'b0;
        status_q     <= MEM_OK;
        done_count_q <= '0;
      end else begin
        if (rd_fire) rd_issued <= rd_issued + 1'b1;
        if (wr_fire) wr_issued <= wr_issued + 1'b1;
        rd_inflight <= rd_inflight + CNT_W'(rd_fire) - CNT_W'(rresp_fire);
        wr_out      <= wr_out + LEN_WIDTH'(wr_fire) - LEN_WIDTH'(wresp_fire);
        // First failing response wins; a read and write error in one cycle report the read.
        if (!err && (rresp_err || wresp_err)) begin
          err      <= 1'b1;
          status_q <= rresp_err ? read_resp_status : write_resp_status;
        end
        if (wresp_fire && (write_resp_status == MEM_OK)) done_count_q <= done_count_q + 1'b1;
      end
    end
  end

  mem_copy_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cmd_fire),
    .push      (fifo_push),
    .push_data (read_resp_data),
    .pop       (wr_fire),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef MEM_COPY_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          perf_cycles <= '0;
    else if (cmd_fire)                   perf_cycles <= '0;
    else if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: paged memory model with randomized backpressure and latency,
// expected copy results computed from the model memory before each command.
module tb_mem_copy_engine;

  localparam logic [3:0] ST_OK       = 4'h0;
  localparam logic [3:0] ST_ERR_ADDR = 4'h1;
  localparam int         DEPTH       = 4;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [15:0] cmd_len;
  logic        done_valid, done_ready;
  logic [3:0]  done_status;
  logic [15:0] done_count;
  logic        read_req_valid, read_req_ready;
  logic [31:0] read_req_addr;
  logic [7:0]  read_req_mask;
  logic        read_resp_valid, read_resp_ready;
  logic [63:0] read_resp_data;
  logic [3:0]  read_resp_status;
  logic        write_req_valid, write_req_ready;
  logic [31:0] write_req_addr;
  logic [7:0]  write_req_mask;
  logic [63:0] write_req_data;
  logic        write_resp_valid, write_resp_ready;
  logic [3:0]  write_resp_status;
`ifdef MEM_COPY_PERF_EN
  logic [31:0] perf_cycles;
`endif

  mem_copy_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_status(done_status), .done_count(done_count),
    .read_req_valid(read_req_valid), .read_req_ready(read_req_ready),
    .read_req_addr(read_req_addr), .read_req_mask(read_req_mask),
    .read_resp_valid(read_resp_valid), .read_resp_ready(read_resp_ready),
    .read_resp_data(read_resp_data), .read_resp_status(read_resp_status),
    .write_req_valid(write_req_valid), .write_req_ready(write_req_ready),
    .write_req_addr(write_req_addr), .write_req_mask(write_req_mask),
    .write_req_data(write_req_data),
    .write_resp_valid(write_resp_valid), .write_resp_ready(write_resp_ready),
    .write_resp_status(write_resp_status)
`ifdef MEM_COPY_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [63:0] pmem [logic [31:0]];

  function automatic bit translate(input logic [31:0] va, output logic [31:0] pa);
    bit ok = 1'b1;
    case (va[31:12])
      20'h0:   pa = {20'h00000, va[11:0]};
      20'h1:   pa = {20'h00008, va[11:0]};
      20'h2:   pa = {20'h00010, va[11:0]};
      default: begin pa = '0; ok = 1'b0; end
    endcase
    return ok;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [31:0] pa);
    if (pmem.exists(pa)) return pmem[pa];
    return {pa ^ 32'hC0DE_0000, ~pa};
  endfunction

  typedef struct { int due; logic [63:0] data; logic [3:0] st; } rsp_t;
  rsp_t rq[$];
  rsp_t wq[$];

  int          cyc = 0;
  int          rd_mode = 0;   // 0 always ready, 1 toggling, 2 random
  bit          wr_bp = 1'b0;
  int          rd_lat = 2, wr_lat = 1;
  int          inflight = 0, max_inflight = 0;
  bit          f_rd, f_rr, f_wr, f_wrr, prev_rd_stall;
  logic [31:0] s_raddr, s_waddr, prev_rd_addr, pa_r;
  logic [7:0]  s_rmask, s_wmask;
  logic [63:0] s_wdata;
  bit          ok_r;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [63:0] wd_log[$];

  // Memory responder: accounts handshakes of the previous edge, then drives the next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete(); wq.delete();
      f_rd = 0; f_rr = 0; f_wr = 0; f_wrr = 0; prev_rd_stall = 0;
      inflight = 0;
      read_req_ready = 0; read_resp_valid = 0; write_req_ready = 0; write_resp_valid = 0;
      read_resp_data = '0; read_resp_status = '0; write_resp_status = '0;
    end else begin
      if (f_rd) begin
        rd_log.push_back(s_raddr);
        check("rd_mask", s_rmask, 8'hFF);
        ok_r = translate(s_raddr, pa_r);
        rq.push_back('{cyc + rd_lat, ok_r ? mem_rd(pa_r) : 64'h0, ok_r ? ST_OK : ST_ERR_ADDR});
        inflight++;
      end
      if (f_rr) begin void'(rq.pop_front()); inflight--; end
      if (f_wr) begin
        wa_log.push_back(s_waddr);
        wd_log.push_back(s_wdata);
        check("wr_mask", s_wmask, 8'hFF);
        ok_r = translate(s_waddr, pa_r);
        if (ok_r) pmem[pa_r] = s_wdata;
        wq.push_back('{cyc + wr_lat, 64'h0, ok_r ? ST_OK : ST_ERR_ADDR});
      end
      if (f_wrr) void'(wq.pop_front());
      if (inflight > max_inflight) max_inflight = inflight;
      if (prev_rd_stall) begin
        check("rd_req_held", read_req_valid, 1);
        check("rd_addr_stable", read_req_addr, prev_rd_addr);
      end
      case (rd_mode)
        0:       read_req_ready = 1'b1;
        1:       read_req_ready = cyc[0];
        default: read_req_ready = 1'($urandom_range(0, 1));
      endcase
      write_req_ready  = wr_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      read_resp_valid  = (rq.size() > 0) && (rq[0].due <= cyc);
      read_resp_data   = read_resp_valid ? rq[0].data : '0;
      read_resp_status = read_resp_valid ? rq[0].st : '0;
      write_resp_valid  = (wq.size() > 0) && (wq[0].due <= cyc);
      write_resp_status = write_resp_valid ? wq[0].st : '0;
      #1;
      f_rd = read_req_valid && read_req_ready;
      s_raddr = read_req_addr; s_rmask = read_req_mask;
      prev_rd_stall = read_req_valid && !read_req_ready;
      prev_rd_addr = read_req_addr;
      f_rr = read_resp_valid && read_resp_ready;
      f_wr = write_req_valid && write_req_ready;
      s_waddr = write_req_addr; s_wmask = write_req_mask; s_wdata = write_req_data;
      f_wrr = write_resp_valid && write_resp_ready;
      cyc++;
    end
  end

  int last_busy = 0;

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input string tag);
    logic [63:0] exp_d[$];
    logic [31:0] pa;
    int          err_idx = -1;
    int          busy = 0;
    for (int k = 0; k < len; k++) begin
      if (!translate(src + 32'(k * 8), pa)) begin
        if (err_idx < 0) err_idx = k;
        exp_d.push_back(64'h0);
      end else begin
        exp_d.push_back(mem_rd(pa));
      end
    end
    @(negedge clk);
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    max_inflight = 0;
    cmd_valid = 1'b1; cmd_src_addr = src; cmd_dst_addr = dst; cmd_len = 16'(len);
    #2 check({tag, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    if (len == 0) check({tag, "_done_next"}, done_valid, 1);
    else          check({tag, "_first_rd"}, read_req_valid, 1);
    while (!done_valid && busy < 2000) begin
      @(negedge clk); #2;
      busy++;
    end
    last_busy = busy;
    check({tag, "_no_timeout"}, busy < 2000, 1);
    check({tag, "_status"}, done_status, (err_idx >= 0) ? ST_ERR_ADDR : ST_OK);
    if (err_idx < 0) begin
      check({tag, "_count"}, done_count, 64'(len));
      check({tag, "_n_rd"}, rd_log.size(), 64'(len));
      check({tag, "_n_wr"}, wa_log.size(), 64'(len));
      for (int k = 0; k < len && k < rd_log.size(); k++)
        check($sformatf("%s_rd_addr%0d", tag, k), rd_log[k], src + 32'(k * 8));
      for (int k = 0; k < len && k < wa_log.size(); k++) begin
        check($sformatf("%s_wr_addr%0d", tag, k), wa_log[k], dst + 32'(k * 8));
        check($sformatf("%s_wr_data%0d", tag, k), wd_log[k], exp_d[k]);
      end
    end else if (err_idx == 0) begin
      check({tag, "_count"}, done_count, 0);
      check({tag, "_n_wr"}, wa_log.size(), 0);
    end
    check({tag, "_max_inflight"}, max_inflight <= DEPTH, 1);
    @(negedge clk); #2;
    check({tag, "_done_hold"}, done_valid, 1);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    #2;
    check({tag, "_idle_ready"}, cmd_ready, 1);
    check({tag, "_done_drop"}, done_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0; done_ready = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_valid", read_req_valid, 0);
    check("rst_wr_valid", write_req_valid, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_status", done_status, 0);
    check("rst_done_count", done_count, 0);
    check("rst_rresp_ready", read_resp_ready, 0);
    rst_n = 1'b1;

    run_copy(32'h0000_0100, 32'h0000_1200, 4, "basic");
    run_copy(32'h0000_0200, 32'h0000_2000, 0, "empty");
    run_copy(32'h0000_5000, 32'h0000_1200, 3, "unmapped");
    rd_mode = 1; wr_lat = 5;
    run_copy(32'h0000_0FF8, 32'h0000_2100, 2, "pagecross");

    for (int i = 0; i < 8; i++) begin
      rd_mode = $urandom_range(0, 2);
      wr_bp   = 1'($urandom_range(0, 1));
      rd_lat  = $urandom_range(1, 6);
      wr_lat  = $urandom_range(1, 6);
      run_copy(32'(8 * $urandom_range(0, 16'h3F0)), 32'h2000 + 32'(8 * $urandom_range(0, 200)),
               $urandom_range(1, 12), $sformatf("rand%0d", i));
    end

    // Reset in the middle of a copy, then a fresh copy must succeed.
    rd_mode = 0; wr_bp = 1; rd_lat = 3; wr_lat = 2;
    @(negedge clk);
    cmd_valid = 1; cmd_src_addr = 32'h300; cmd_dst_addr = 32'h2800; cmd_len = 16'd10;
    @(negedge clk);
    cmd_valid = 0;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_rd_valid", read_req_valid, 0);
    check("midrst_wr_valid", write_req_valid, 0);
    check("midrst_rresp_ready", read_resp_ready, 0);
    check("midrst_wresp_ready", write_resp_ready, 0);
    check("midrst_done_valid", done_valid, 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #2;
    check("midrst_cmd_ready", cmd_ready, 1);
    wr_bp = 0;
    run_copy(32'h0000_0400, 32'h0000_2A00, 6, "after_rst");

    rd_mode = 0; wr_bp = 0; rd_lat = 1; wr_lat = 1;
    run_copy(32'h0000_0500, 32'h0000_2C00, 4, "perf");
`ifdef MEM_COPY_PERF_EN
    check("perf_cycles", perf_cycles, 64'(last_busy));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
